// File: rtl/pipelined_lead_normalizer_if.sv
// Handshake bundle for pipelined_lead_normalizer: the input transaction channel and the result channel.
// The slave modport is the normaliser's view; master is the producer/consumer view.
interface pipelined_lead_normalizer_if #(
    parameter int WIDTH = 24,
    parameter int TAG_W = 4
);
    localparam int POS_W = $clog2(WIDTH);
    localparam int SH_W  = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_value;
    logic             in_mode;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic             out_has_lead;
    logic [POS_W-1:0] out_position;
    logic [SH_W-1:0]  out_shift;
    logic [WIDTH-1:0] out_norm;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_value, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_has_lead, out_position, out_shift, out_norm, out_tag
    );

    modport slave (
        input  in_valid, in_value, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_has_lead, out_position, out_shift, out_norm, out_tag
    );
endinterface

// File: rtl/pipelined_lead_normalizer.sv
// Back-pressured leading-one / leading-sign detector and left normaliser with a fixed PIPE_STAGES latency.
// The detection is evaluated ahead of stage 1 so every stage holds a finished result; port timing is unchanged.
module pipelined_lead_normalizer #(
    parameter int WIDTH       = 24,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    pipelined_lead_normalizer_if.slave bus
);
    localparam int POS_W = $clog2(WIDTH);
    localparam int SH_W  = $clog2(WIDTH + 1);

    typedef struct packed {
        logic             has_lead;
        logic [POS_W-1:0] position;
        logic [SH_W-1:0]  shift;
        logic [WIDTH-1:0] norm;
        logic [TAG_W-1:0] tag;
    } result_t;

    function automatic result_t detect(input logic [WIDTH-1:0] value,
                                       input logic             mode,
                                       input logic [TAG_W-1:0] tag);
        result_t r;
        // NOTE: every field gets a default before the conditional scans, so no path leaves one unassigned.
        r     = '0;
        r.tag = tag;
        if (!mode) begin
            r.shift = SH_W'(WIDTH);
            for (int i = 0; i < WIDTH; i++) begin
                if (value[i]) begin
                    r.has_lead = 1'b1;
                    r.position = POS_W'(i);
                    r.shift    = SH_W'(WIDTH - 1 - i);
                end
            end
        end else begin
            r.shift = SH_W'(WIDTH - 1);
            for (int i = 0; i < WIDTH - 1; i++) begin
                if (value[i] != value[WIDTH-1]) begin
                    r.has_lead = 1'b1;
                    r.position = POS_W'(i);
                    r.shift    = SH_W'(WIDTH - 2 - i);
                end
            end
        end
        r.norm = value << r.shift;
        return r;
    endfunction

    result_t                in_result;
    result_t                stage_data [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] stage_valid;
    logic [PIPE_STAGES-1:0] stage_ready;

    assign in_result = detect(bus.in_value, bus.in_mode, bus.in_tag);

    // A stage can take new data unless it and every stage after it are full and the sink is stalled.
    always_comb begin
        logic all_full;
        all_full    = 1'b1;
        stage_ready = '0;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            all_full       = all_full & stage_valid[k];
            stage_ready[k] = bus.out_ready || !all_full;
        end
    end

    assign bus.in_ready = stage_ready[0] && !flush;

    // NOTE: registered state is updated only with '<=' so every stage samples its predecessor's old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= '0;
            // NOTE: the data registers are reset too, so the result ports read all-zero during and after reset.
            for (int k = 0; k < PIPE_STAGES; k++) begin
                stage_data[k] <= '0;
            end
        end else begin
            if (stage_ready[0]) begin
                stage_valid[0] <= bus.in_valid && !flush;
                if (bus.in_valid && !flush) begin
                    stage_data[0] <= in_result;
                end
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (stage_ready[k]) begin
                    stage_valid[k] <= stage_valid[k-1];
                    if (stage_valid[k-1]) begin
                        stage_data[k] <= stage_data[k-1];
                    end
                end
            end
            if (flush) begin
                stage_valid <= '0;
            end
        end
    end

    assign bus.out_valid    = stage_valid[PIPE_STAGES-1];
    assign bus.out_has_lead = stage_data[PIPE_STAGES-1].has_lead;
    assign bus.out_position = stage_data[PIPE_STAGES-1].position;
    assign bus.out_shift    = stage_data[PIPE_STAGES-1].shift;
    assign bus.out_norm     = stage_data[PIPE_STAGES-1].norm;
    assign bus.out_tag      = stage_data[PIPE_STAGES-1].tag;
endmodule

// File: tb/tb_pipelined_lead_normalizer.sv
// Self-checking bench for pipelined_lead_normalizer (WIDTH=8, PIPE_STAGES=2, TAG_W=4).
// Results are predicted arithmetically and tracked in an in-order scoreboard queue.
module tb_pipelined_lead_normalizer;
    localparam int WIDTH = 8;
    localparam int N     = 2;
    localparam int TAG_W = 4;

    typedef struct {
        logic       has;
        logic [2:0] pos;
        logic [3:0] sh;
        logic [7:0] norm;
        logic [3:0] tag;
        int         acc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;

    pipelined_lead_normalizer_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus_if ();

    pipelined_lead_normalizer #(.WIDTH(WIDTH), .PIPE_STAGES(N), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   n_pop = 0;
    bit   check_lat = 1'b0;
    bit   last_accept;
    bit   saw_block;
    exp_t q[$];

    // Reference: leading one = floor(log2(v)); leading sign digit = leading one of (v xor sign) below the MSB.
    function automatic exp_t model(input logic [7:0] v, input logic m, input logic [3:0] tag);
        exp_t e;
        int   t;
        int   p;
        int   sh;
        if (!m) begin
            t = int'(v);
            if (t == 0) begin e.has = 1'b0; p = 0; sh = 8; end
            else begin e.has = 1'b1; p = $clog2(t + 1) - 1; sh = 7 - p; end
        end else begin
            t = int'((v[7] ? ~v : v) & 8'h7F);
            if (t == 0) begin e.has = 1'b0; p = 0; sh = 7; end
            else begin e.has = 1'b1; p = $clog2(t + 1) - 1; sh = 6 - p; end
        end
        e.pos  = 3'(p);
        e.sh   = 4'(sh);
        e.norm = 8'((int'(v) << sh) & 255);
        e.tag  = tag;
        e.acc  = cyc;
        return e;
    endfunction

    // One clock: sample just before the rising edge, then advance to 1 time unit after it.
    task automatic cycle();
        exp_t e;
        logic exp_ready;
        #3;
        exp_ready   = !flush && (q.size() < N || bus_if.out_ready);
        saw_block   = saw_block | (bus_if.in_ready === 1'b0 && !flush);
        n_cmp++;
        if (bus_if.in_ready !== exp_ready) begin
            n_bad++;
            $display("FAIL in_ready cyc=%0d: got %b want %b", cyc, bus_if.in_ready, exp_ready);
        end
        if (bus_if.out_valid === 1'b1) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output cyc=%0d: got tag=%0d want no result", cyc, bus_if.out_tag);
            end else begin
                e = q[0];
                if ({bus_if.out_has_lead, bus_if.out_position, bus_if.out_shift, bus_if.out_norm, bus_if.out_tag}
                    !== {e.has, e.pos, e.sh, e.norm, e.tag}) begin
                    n_bad++;
                    $display("FAIL result cyc=%0d: got has=%b pos=%0d sh=%0d norm=%h tag=%0d want has=%b pos=%0d sh=%0d norm=%h tag=%0d",
                             cyc, bus_if.out_has_lead, bus_if.out_position, bus_if.out_shift, bus_if.out_norm,
                             bus_if.out_tag, e.has, e.pos, e.sh, e.norm, e.tag);
                end
                if (bus_if.out_ready && !flush) begin
                    if (check_lat) begin
                        n_cmp++;
                        if (cyc - e.acc != N) begin
                            n_bad++;
                            $display("FAIL latency tag=%0d: got %0d want %0d", e.tag, cyc - e.acc, N);
                        end
                    end
                    void'(q.pop_front());
                    n_pop++;
                end
            end
        end else if (bus_if.out_valid !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out_valid_x cyc=%0d: got %b want 0/1", cyc, bus_if.out_valid);
        end
        last_accept = bus_if.in_valid && exp_ready;
        if (last_accept) q.push_back(model(bus_if.in_value, bus_if.in_mode, bus_if.in_tag));
        if (flush) q.delete();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        flush            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 12 && q.size() > 0; i++) cycle();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d items left want 0", q.size());
            q.delete();
        end
    endtask

    task automatic send(input logic [7:0] v, input logic m, input logic [3:0] tag);
        bus_if.in_valid = 1'b1;
        bus_if.in_value = v;
        bus_if.in_mode  = m;
        bus_if.in_tag   = tag;
        cycle();
        bus_if.in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic has, input logic [2:0] pos,
                              input logic [3:0] sh, input logic [7:0] norm, input logic [3:0] tag);
        int k;
        k = 1;
        while (bus_if.out_valid !== 1'b1 && k < 8) begin
            cycle();
            k++;
        end
        n_cmp++;
        if (k != N) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d want %0d", name, k, N);
        end
        n_cmp++;
        if ({bus_if.out_has_lead, bus_if.out_position, bus_if.out_shift, bus_if.out_norm, bus_if.out_tag}
            !== {has, pos, sh, norm, tag}) begin
            n_bad++;
            $display("FAIL %s: got has=%b pos=%0d sh=%0d norm=%h tag=%0d want has=%b pos=%0d sh=%0d norm=%h tag=%0d",
                     name, bus_if.out_has_lead, bus_if.out_position, bus_if.out_shift, bus_if.out_norm,
                     bus_if.out_tag, has, pos, sh, norm, tag);
        end
        cycle();
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus_if.out_valid, bus_if.out_has_lead, bus_if.out_position, bus_if.out_shift,
             bus_if.out_norm, bus_if.out_tag} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b norm=%h tag=%0d want all 0",
                     bus_if.out_valid, bus_if.out_norm, bus_if.out_tag);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_mode0();
        bus_if.out_ready = 1'b1;
        send(8'h13, 1'b0, 4'd5);
        expect_out("mode0_0x13", 1'b1, 3'd4, 4'd3, 8'h98, 4'd5);
        send(8'h00, 1'b0, 4'd6);
        expect_out("mode0_zero", 1'b0, 3'd0, 4'd8, 8'h00, 4'd6);
    endtask

    task automatic test_mode1();
        send(8'hF3, 1'b1, 4'd1);
        expect_out("mode1_0xF3", 1'b1, 3'd3, 4'd3, 8'h98, 4'd1);
        send(8'hFF, 1'b1, 4'd2);
        expect_out("mode1_0xFF", 1'b0, 3'd0, 4'd7, 8'h80, 4'd2);
        send(8'h01, 1'b1, 4'd3);
        expect_out("mode1_0x01", 1'b1, 3'd0, 4'd6, 8'h40, 4'd3);
        send(8'h00, 1'b1, 4'd4);
        expect_out("mode1_zero", 1'b0, 3'd0, 4'd7, 8'h00, 4'd4);
    endtask

    task automatic test_back_to_back();
        int pops0;
        pops0     = n_pop;
        check_lat = 1'b1;
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_value = 8'($urandom);
            bus_if.in_mode  = 1'($urandom);
            bus_if.in_tag   = 4'(i);
            cycle();
        end
        drain();
        check_lat = 1'b0;
        n_cmp++;
        if (n_pop - pops0 != 8) begin
            n_bad++;
            $display("FAIL back_to_back_count: got %0d want 8", n_pop - pops0);
        end
    endtask

    task automatic test_stall();
        int idx;
        int pops0;
        idx       = 0;
        pops0     = n_pop;
        saw_block = 1'b0;
        for (int c = 0; c < 30 && idx < 6; c++) begin
            bus_if.out_ready = !(c >= 2 && c < 5);
            bus_if.in_valid  = 1'b1;
            bus_if.in_value  = 8'($urandom);
            bus_if.in_mode   = 1'($urandom);
            bus_if.in_tag    = 4'(idx);
            cycle();
            if (last_accept) idx++;
        end
        drain();
        n_cmp++;
        if (saw_block !== 1'b1 || n_pop - pops0 != 6) begin
            n_bad++;
            $display("FAIL stall: got blocked=%b popped=%0d want blocked=1 popped=6", saw_block, n_pop - pops0);
        end
    endtask

    task automatic test_flush();
        bus_if.out_ready = 1'b1;
        send(8'h21, 1'b0, 4'd9);
        send(8'h42, 1'b0, 4'd10);
        flush           = 1'b1;
        bus_if.in_valid = 1'b1;
        bus_if.in_value = 8'h84;
        bus_if.in_tag   = 4'd11;
        #1;
        n_cmp++;
        if (bus_if.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_in_ready: got %b want 0", bus_if.in_ready);
        end
        cycle();
        flush           = 1'b0;
        bus_if.in_valid = 1'b0;
        n_cmp++;
        if (bus_if.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_out_valid: got %b want 0", bus_if.out_valid);
        end
        for (int i = 0; i < 4; i++) cycle();
    endtask

    task automatic test_reset_midstream();
        bus_if.out_ready = 1'b1;
        send(8'h35, 1'b0, 4'd12);
        send(8'h0C, 1'b1, 4'd13);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus_if.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_midstream_out_valid: got %b want 0", bus_if.out_valid);
        end
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus_if.in_valid  = ($urandom % 4) != 0;
            bus_if.out_ready = ($urandom % 4) != 0;
            flush            = ($urandom % 40) == 0;
            bus_if.in_value  = 8'($urandom);
            bus_if.in_mode   = 1'($urandom);
            bus_if.in_tag    = 4'($urandom);
            cycle();
        end
        drain();
    endtask

    initial begin
        rst_n            = 1'b0;
        flush            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_value  = '0;
        bus_if.in_mode   = 1'b0;
        bus_if.in_tag    = '0;
        bus_if.out_ready = 1'b1;
        last_accept      = 1'b0;
        saw_block        = 1'b0;
        #1;
        test_reset();
        test_mode0();
        test_mode1();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
